// File: rtl/sync_fifo_pkg.sv
// Shared types for the FIFO read-side prefetch logic.
package sync_fifo_pkg;

    localparam int PREFETCH_DEPTH = 3;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] cnt_t;

    // Advance a buffer pointer, wrapping after the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(PREFETCH_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo_reader_buf.sv
// Three-entry prefetch register file. The head is kept in its own register so
// the stream data holds its last value once the buffer drains.
module sync_fifo_reader_buf
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output cnt_t                  o_count
);

    logic [DATA_WIDTH-1:0] r_mem [PREFETCH_DEPTH];
    logic [DATA_WIDTH-1:0] r_head;
    ptr_t                  r_wr_ptr;
    ptr_t                  r_rd_ptr;
    cnt_t                  r_count;
    ptr_t                  w_rd_nxt;

    assign w_rd_nxt = ptr_inc(r_rd_ptr);
    assign o_head   = r_head;
    assign o_count  = r_count;

    // Storage, pointers, occupancy and registered head; flush beats a capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) r_mem[i] <= '0;
            r_head   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) r_rd_ptr <= w_rd_nxt;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
            // Next head: the entry behind the popped one, or the incoming
            // word when it lands in an otherwise empty buffer.
            if (i_pop) begin
                if (r_count == cnt_t'(1)) begin
                    if (i_push) r_head <= i_data;
                end else begin
                    r_head <= r_mem[w_rd_nxt];
                end
            end else if (i_push && (r_count == '0)) begin
                r_head <= i_data;
            end
        end
    end

    // Credit accounting upstream must never let a word arrive into a full buffer.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_pop && !i_flush && (r_count == cnt_t'(PREFETCH_DEPTH))));

endmodule

// File: rtl/sync_fifo_reader.sv
// FIFO read-side master: issues reads against buffer credit, captures the
// returning word one cycle later and presents it as a valid/ready stream.
// The first word becomes visible two cycles after its read strobe.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  read_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

    logic                 r_inflight;
    logic                 r_drop;
    logic [CNT_WIDTH-1:0] r_xfer;
    cnt_t                 w_count;
    logic [2:0]           w_credit_used;
    logic                 w_push;
    logic                 w_pop;

    // Buffered words plus the one on its way back; ready is deliberately absent
    // so the read strobe never depends on the downstream consumer.
    assign w_credit_used = {1'b0, w_count} + {2'b00, r_inflight};
    assign read_o        = rst_n_i & ~empty_i & ~flush_i
                         & (w_credit_used < 3'(PREFETCH_DEPTH));

    assign m_valid_o  = (w_count != '0);
    assign w_pop      = m_valid_o & m_ready_i;
    assign w_push     = r_inflight & ~r_drop;
    assign xfer_cnt_o = r_xfer;

    sync_fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_data  (rd_data_i),
        .i_pop   (w_pop),
        .o_head  (m_data_o),
        .o_count (w_count)
    );

    // Track the outstanding read, the post-flush discard and completed handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            r_xfer     <= '0;
        end else begin
            r_inflight <= read_o;
            r_drop     <= flush_i & r_inflight;
            if (w_pop) r_xfer <= r_xfer + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader with a behavioural FIFO on the read side.
module tb_sync_fifo_reader;

    logic        clk_i = 1'b0;
    logic        rst_n_i, flush_i, empty_i, m_ready_i;
    logic [31:0] rd_data_i;
    logic        read_o, m_valid_o;
    logic [31:0] m_data_o;
    logic [15:0] xfer_cnt_o;
    logic        read_w, valid_w;
    logic [31:0] data_w;
    logic [3:0]  xfer_w;

    int checks = 0;
    int failures = 0;

    logic [31:0] fq[$];
    logic [31:0] got[$];
    logic [31:0] pend;
    bit          was_rd;
    logic        s_rd, s_vld;
    logic [31:0] s_dat;
    logic [15:0] s_cnt;
    logic [3:0]  s_cntw;

    always #5 clk_i = ~clk_i;

    sync_fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .empty_i(empty_i),
        .rd_data_i(rd_data_i), .read_o(read_o), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .xfer_cnt_o(xfer_cnt_o)
    );

    sync_fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_w (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .empty_i(empty_i),
        .rd_data_i(rd_data_i), .read_o(read_w), .m_data_o(data_w),
        .m_valid_o(valid_w), .m_ready_i(m_ready_i), .xfer_cnt_o(xfer_w)
    );

    // One clock cycle, entered and left at negedge. Presents the word popped
    // last cycle, samples outputs, then pops the FIFO model if read_o is high.
    task automatic cyc();
        rd_data_i = was_rd ? pend : 32'hDEAD_BEEF;
        empty_i   = (fq.size() == 0);
        #1;
        s_rd   = read_o;
        s_vld  = m_valid_o;
        s_dat  = m_data_o;
        s_cnt  = xfer_cnt_o;
        s_cntw = xfer_w;
        if (s_vld && m_ready_i) got.push_back(s_dat);
        was_rd = s_rd;
        if (s_rd && fq.size() != 0) pend = fq.pop_front();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; m_ready_i = 1'b0;
        fq.delete(); got.delete(); was_rd = 1'b0;
        cyc(); cyc();
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; m_ready_i = 1'b0;
        fq.delete(); got.delete(); was_rd = 1'b0;
        fq.push_back(32'h1); fq.push_back(32'h2);
        cyc();
        checks++; if (s_rd !== 1'b0) begin failures++; $display("FAIL reset_read_o got=%0b exp=0", s_rd); end
        cyc();
        checks++; if (s_rd !== 1'b0) begin failures++; $display("FAIL reset_read_o2 got=%0b exp=0", s_rd); end
        checks++; if (s_vld !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", s_vld); end
        checks++; if (s_dat !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", s_dat); end
        checks++; if (s_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", s_cnt); end
        checks++; if (s_cntw !== 4'h0) begin failures++; $display("FAIL reset_cntw got=%0d exp=0", s_cntw); end
    endtask

    task automatic test_stream();
        bit [0:7]    exp_rd  = 8'b1111_0000;
        bit [0:7]    exp_vld = 8'b0011_1100;
        logic [31:0] exp_dat [8] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0};
        do_reset();
        fq = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++; if (s_rd !== exp_rd[k]) begin failures++; $display("FAIL stream_read k=%0d got=%0b exp=%0b", k, s_rd, exp_rd[k]); end
            checks++; if (s_vld !== exp_vld[k]) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, s_vld, exp_vld[k]); end
            if (exp_vld[k]) begin
                checks++; if (s_dat !== exp_dat[k]) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, s_dat, exp_dat[k]); end
            end
        end
        checks++; if (s_dat !== 32'h44) begin failures++; $display("FAIL stream_hold got=%h exp=44", s_dat); end
        checks++; if (s_cnt !== 16'd4) begin failures++; $display("FAIL stream_cnt got=%0d exp=4", s_cnt); end
    endtask

    task automatic test_backpressure();
        bit [0:6] exp_rd  = 7'b1110000;
        bit [0:5] exp_rd2 = 6'b010000;
        logic [31:0] exp_got [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        fq = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            checks++; if (s_rd !== exp_rd[k]) begin failures++; $display("FAIL bp_read k=%0d got=%0b exp=%0b", k, s_rd, exp_rd[k]); end
        end
        checks++; if (s_vld !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", s_vld); end
        checks++; if (s_dat !== 32'h11) begin failures++; $display("FAIL bp_head got=%h exp=11", s_dat); end
        m_ready_i = 1'b1;
        got.delete();
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++; if (s_rd !== exp_rd2[k]) begin failures++; $display("FAIL bp_read2 k=%0d got=%0b exp=%0b", k, s_rd, exp_rd2[k]); end
        end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_got[i]) begin failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], exp_got[i]); end
        end
        checks++; if (s_cnt !== 16'd4) begin failures++; $display("FAIL bp_cnt got=%0d exp=4", s_cnt); end
    endtask

    task automatic test_empty();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            m_ready_i = 1'($urandom_range(0, 1));
            cyc();
            checks++; if (s_rd !== 1'b0) begin failures++; $display("FAIL empty_read k=%0d got=%0b exp=0", k, s_rd); end
            checks++; if (s_vld !== 1'b0) begin failures++; $display("FAIL empty_valid k=%0d got=%0b exp=0", k, s_vld); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        fq = '{32'hA1, 32'hA2, 32'hA3, 32'h55};
        m_ready_i = 1'b0;
        cyc(); cyc(); cyc();
        // two words buffered, A3 returning during the flush cycle
        flush_i = 1'b1;
        cyc();
        checks++; if (s_rd !== 1'b0) begin failures++; $display("FAIL flush_read got=%0b exp=0", s_rd); end
        checks++; if (s_vld !== 1'b1) begin failures++; $display("FAIL flush_prevalid got=%0b exp=1", s_vld); end
        flush_i = 1'b0;
        m_ready_i = 1'b1;
        got.delete();
        cyc();
        checks++; if (s_vld !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", s_vld); end
        checks++; if (s_rd !== 1'b1) begin failures++; $display("FAIL flush_reread got=%0b exp=1", s_rd); end
        for (int k = 0; k < 5; k++) cyc();
        checks++; if (got.size() != 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", got.size()); end
        if (got.size() != 0) begin
            checks++; if (got[0] !== 32'h55) begin failures++; $display("FAIL flush_first got=%h exp=55", got[0]); end
        end
        checks++; if (s_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", s_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fq = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        m_ready_i = 1'b1;
        cyc(); cyc(); cyc();
        rst_n_i = 1'b0;
        cyc();
        checks++; if (s_rd !== 1'b0) begin failures++; $display("FAIL midrst_read got=%0b exp=0", s_rd); end
        rst_n_i = 1'b1;
        got.delete();
        cyc();
        checks++; if (s_vld !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", s_vld); end
        checks++; if (s_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", s_cnt); end
        for (int k = 0; k < 5; k++) cyc();
        checks++; if (got.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", got.size()); end
        if (got.size() != 0) begin
            checks++; if (got[0] !== 32'hB4) begin failures++; $display("FAIL midrst_first got=%h exp=b4", got[0]); end
        end
        checks++; if (s_cnt !== 16'd1) begin failures++; $display("FAIL midrst_cnt2 got=%0d exp=1", s_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) fq.push_back(32'h100 + 32'(i));
        m_ready_i = 1'b1;
        for (int k = 0; k < 24; k++) cyc();
        checks++; if (got.size() != 17) begin failures++; $display("FAIL wrap_count got=%0d exp=17", got.size()); end
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            checks++; if (got[i] !== 32'h100 + 32'(i)) begin failures++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, got[i], 32'h100 + 32'(i)); end
        end
        checks++; if (s_cnt !== 16'd17) begin failures++; $display("FAIL wrap_cnt16 got=%0d exp=17", s_cnt); end
        checks++; if (s_cntw !== 4'd1) begin failures++; $display("FAIL wrap_cnt4 got=%0d exp=1", s_cntw); end
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; empty_i = 1'b1; m_ready_i = 1'b0;
        rd_data_i = '0; was_rd = 1'b0; pend = '0;
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
